// File: rtl/risc_loader.sv
// risc_loader: streams a program image into the core memory while the
// core is held in reset, then releases it and times the run to halt.
module risc_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    input  logic              cpu_halt,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  run_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BOOT1,
        S_BOOT2,
        S_RUN,
        S_HALT
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic              accept;
    logic              restart;

    // Handshake and restart qualifiers; load_req is ignored mid-load/boot.
    always_comb begin
        accept  = in_valid && in_ready_q;
        restart = load_req &&
                  (state_q inside {S_IDLE, S_RUN, S_HALT});
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        in_ready_d  = in_ready_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        run_d       = run_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_LOAD: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_data;
                    addr_d      = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        addr_d     = '0;
                        in_ready_d = 1'b0;
                        state_d    = S_BOOT1;
                    end
                end
            end
            S_BOOT1: begin
                // One idle cycle so the final write lands first.
                state_d = S_BOOT2;
            end
            S_BOOT2: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cpu_halt) begin
                    state_d = S_HALT;
                end else if (run_q != CNT_MAX) begin
                    run_d = run_q + 1'b1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
            end
        endcase

        if (restart) begin
            state_d    = S_LOAD;
            addr_d     = '0;
            run_d      = '0;
            in_ready_d = 1'b1;
        end

        cpu_rst_d = !(state_d inside {S_RUN, S_HALT});
        busy_d    = state_d inside {S_LOAD, S_BOOT1, S_BOOT2, S_RUN};
        done_d    = (state_d == S_HALT);
    end

    // State and output registers; reset forces the core back into reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            run_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            run_q       <= run_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign run_cycles = run_q;

endmodule

// File: tb/tb_risc_loader.sv
// tb_risc_loader: directed + randomized checks of load, boot, run count,
// restart, asynchronous reset and counter saturation.
module tb_risc_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        cpu_halt;

    logic        in_ready, mem_we, cpu_rst, busy, done;
    logic [4:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [15:0] run_cycles;

    logic        s_in_ready, s_mem_we, s_cpu_rst, s_busy, s_done;
    logic [4:0]  s_mem_addr;
    logic [7:0]  s_mem_wdata;
    logic [3:0]  s_run;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         log_addr[$];
    logic [7:0] log_data[$];
    int         log_cyc[$];
    logic [7:0] img[32];

    always #5 clk = ~clk;

    risc_loader u_dut (
        .clk(clk), .rst(rst_n), .load_req(load_req),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .cpu_halt(cpu_halt), .busy(busy),
        .done(done), .run_cycles(run_cycles)
    );

    risc_loader #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst_n), .load_req(load_req),
        .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .cpu_rst(s_cpu_rst), .cpu_halt(cpu_halt), .busy(s_busy),
        .done(s_done), .run_cycles(s_run)
    );

    // Memory model: record every committed write with its edge number.
    always @(posedge clk) begin
        if (mem_we) begin
            log_addr.push_back(int'(mem_addr));
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        chk({tag, " nwrites"}, log_addr.size(), 32);
        if (log_addr.size() == 32) begin
            for (int k = 0; k < 32; k++) begin
                chk($sformatf("%s addr%0d", tag, k), log_addr[k], k);
                chk($sformatf("%s data%0d", tag, k), log_data[k], img[k]);
            end
        end
    endtask

    task automatic boot_checks(input string tag);
        tick();
        chk({tag, " boot1 cpu_rst"}, cpu_rst, 1);
        chk({tag, " boot1 mem_we"}, mem_we, 0);
        chk({tag, " boot1 busy"}, busy, 1);
        tick();
        chk({tag, " boot2 cpu_rst"}, cpu_rst, 0);
        chk({tag, " boot2 busy"}, busy, 1);
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cpu_halt = 1'b0;

        // Reset values
        #12;
        chk("rst in_ready", in_ready, 0);
        chk("rst mem_we", mem_we, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst cpu_rst", cpu_rst, 1);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst run_cycles", run_cycles, 0);
        chk("rst s_in_ready", s_in_ready, 0);
        chk("rst s_mem_we", s_mem_we, 0);
        chk("rst s_mem_addr", s_mem_addr, 0);
        chk("rst s_mem_wdata", s_mem_wdata, 0);
        chk("rst s_cpu_rst", s_cpu_rst, 1);
        chk("rst s_busy", s_busy, 0);
        chk("rst s_done", s_done, 0);
        chk("rst s_run", s_run, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle busy", busy, 0);
        chk("idle in_ready", in_ready, 0);

        // Full-rate load, data = address + 0x40
        for (int i = 0; i < 32; i++) img[i] = 8'(i + 8'h40);
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("full E0 in_ready", in_ready, 1);
        chk("full E0 busy", busy, 1);
        chk("full E0 cpu_rst", cpu_rst, 1);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = img[i];
            tick();
            chk($sformatf("full we%0d", i), mem_we, 1);
            chk($sformatf("full addr%0d", i), mem_addr, i);
            chk($sformatf("full data%0d", i), mem_wdata, img[i]);
            chk($sformatf("full rdy%0d", i), in_ready, (i < 31) ? 1 : 0);
        end
        in_valid = 1'b0;
        boot_checks("full");
        check_log("full");

        // Run count: halt sampled on the 7th RUN edge
        cpu_halt = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("run cnt%0d", k), run_cycles, k);
            chk($sformatf("run busy%0d", k), busy, 1);
        end
        cpu_halt = 1'b1;
        tick();
        chk("halt done", done, 1);
        chk("halt busy", busy, 0);
        chk("halt run_cycles", run_cycles, 6);
        cpu_halt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("frozen cnt%0d", k), run_cycles, 6);
            chk($sformatf("frozen done%0d", k), done, 1);
            chk($sformatf("frozen cpu_rst%0d", k), cpu_rst, 0);
        end

        // Restart from HALTED, gapped random image
        for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("restart cpu_rst", cpu_rst, 1);
        chk("restart done", done, 0);
        chk("restart in_ready", in_ready, 1);
        chk("restart run_cycles", run_cycles, 0);
        chk("restart busy", busy, 1);
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = img[i];
            tick();
            chk($sformatf("gap addr%0d", i), mem_addr, i);
            chk($sformatf("gap we%0d", i), mem_we, 1);
            if (i < 31) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                load_req = (i == 10);
                tick();
                load_req = 1'b0;
                chk($sformatf("gap idle we%0d", i), mem_we, 0);
                chk($sformatf("gap idle rdy%0d", i), in_ready, 1);
            end
        end
        in_valid = 1'b0;
        boot_checks("gap");
        check_log("gap");
        if (log_cyc.size() == 32)
            chk("gap span", log_cyc[31] - log_cyc[0], 62);

        n = int'($urandom_range(1, 40));
        for (int k = 0; k < n; k++) tick();
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk("rand run_cycles", run_cycles, n);
        chk("rand done", done, 1);
        chk("rand sat run", s_run, (n > 15) ? 15 : n);

        // Asynchronous reset after 10 accepts
        log_addr.delete(); log_data.delete(); log_cyc.delete();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        chk("pre-rst mem_we", mem_we, 1);
        chk("pre-rst addr", mem_addr, 9);
        rst_n = 1'b0;
        #1;
        chk("async cpu_rst", cpu_rst, 1);
        chk("async in_ready", in_ready, 0);
        chk("async mem_we", mem_we, 0);
        chk("async busy", busy, 0);
        chk("async run_cycles", run_cycles, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post-rst rdy%0d", k), in_ready, 0);
            chk($sformatf("post-rst we%0d", k), mem_we, 0);
            chk($sformatf("post-rst busy%0d", k), busy, 0);
        end
        chk("post-rst nwrites", log_addr.size(), 9);
        in_valid = 1'b0;

        // Saturation of the 4-bit counter over 20 RUN edges
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        boot_checks("sat");
        for (int k = 0; k < 20; k++) tick();
        chk("sat s_run", s_run, 4'hF);
        chk("sat wide run", run_cycles, 20);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        chk("sat s_done", s_done, 1);
        chk("sat s_run halt", s_run, 4'hF);
        chk("sat wide halt", run_cycles, 20);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
